// File: rtl/pa_fpu.sv
// rtl/pa_fpu.sv - shared FPU package: divider FSM states and default widths
package pa_fpu;

  localparam int DIV_QWIDTH_DEF = 27;

  typedef enum logic [1:0] {
    pdiv_idle_st         = 2'd0,
    pdiv_iter_st         = 2'd1,
    pdiv_result_valid_st = 2'd2
  } e_pdiv_st;

  // Iterations per operation: one quotient bit per clock.
  function automatic int pdiv_iters(input logic mode_int, input int width, input int qwidth);
    return mode_int ? width : qwidth;
  endfunction

endpackage

// File: rtl/fpu_iter_div.sv
// rtl/fpu_iter_div.sv - iterative restoring divider, mantissa and integer modes
// Optional divide-by-zero shortcut and dbz flag under `FPU_DIV_DBZ_EN.
module fpu_iter_div
  import pa_fpu::*;
#(
  parameter int WIDTH  = 24,
  parameter int QWIDTH = WIDTH + 3
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              start,
  input  logic              mode_int,
  input  logic [WIDTH-1:0]  dividend,
  input  logic [WIDTH-1:0]  divisor,
  input  logic              ack,
  output logic              busy,
  output logic              result_valid,
  output logic [QWIDTH-1:0] quotient,
  output logic [WIDTH:0]    remainder,
  output logic              sticky,
  output logic              dbz
);

  localparam int CW = $clog2(QWIDTH + 1);

  e_pdiv_st          r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_mode_int;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH:0]    r_rem;
  logic [QWIDTH-1:0] r_q;

  logic              r_busy;
  logic              r_valid;
  logic [QWIDTH-1:0] r_quot;
  logic [WIDTH:0]    r_remd;
  logic              r_sticky;
`ifdef FPU_DIV_DBZ_EN
  logic              r_dbz;
`endif

  logic [WIDTH:0]    w_rem_in;
  logic [WIDTH:0]    w_rem_sub;
  logic [WIDTH:0]    w_rem_next;
  logic [QWIDTH-1:0] w_q_next;
  logic              w_ge;
  logic              w_last;

  // One restoring step; integer mode first pulls in the next dividend bit.
  always_comb begin
    w_rem_in   = r_mode_int ? {r_rem[WIDTH-1:0], r_a[WIDTH-1]} : r_rem;
    w_ge       = (w_rem_in >= {1'b0, r_b});
    w_rem_sub  = w_ge ? (w_rem_in - {1'b0, r_b}) : w_rem_in;
    w_q_next   = {r_q[QWIDTH-2:0], w_ge};
    w_last     = (r_cnt == CW'(1));
    w_rem_next = (r_mode_int || w_last) ? w_rem_sub : {w_rem_sub[WIDTH-1:0], 1'b0};
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state    <= pdiv_idle_st;
      r_cnt      <= '0;
      r_mode_int <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_rem      <= '0;
      r_q        <= '0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_quot     <= '0;
      r_remd     <= '0;
      r_sticky   <= 1'b0;
`ifdef FPU_DIV_DBZ_EN
      r_dbz      <= 1'b0;
`endif
    end else begin
      case (r_state)
        pdiv_idle_st: begin
          if (start) begin
            r_mode_int <= mode_int;
            r_a        <= dividend;
            r_b        <= divisor;
            r_rem      <= mode_int ? '0 : {1'b0, dividend};
            r_q        <= '0;
            r_cnt      <= CW'(pdiv_iters(mode_int, WIDTH, QWIDTH));
            r_busy     <= 1'b1;
`ifdef FPU_DIV_DBZ_EN
            if (divisor == '0) begin
              r_state  <= pdiv_result_valid_st;
              r_valid  <= 1'b1;
              r_quot   <= '1;
              r_remd   <= {1'b0, dividend};
              r_sticky <= |dividend;
              r_dbz    <= 1'b1;
            end else begin
              r_state  <= pdiv_iter_st;
            end
`else
            r_state    <= pdiv_iter_st;
`endif
          end
        end
        pdiv_iter_st: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          r_a   <= {r_a[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_state  <= pdiv_result_valid_st;
            r_valid  <= 1'b1;
            r_quot   <= w_q_next;
            r_remd   <= w_rem_sub;
            r_sticky <= |w_rem_sub;
`ifdef FPU_DIV_DBZ_EN
            r_dbz    <= 1'b0;
`endif
          end
        end
        pdiv_result_valid_st: begin
          if (ack) begin
            r_state <= pdiv_idle_st;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= pdiv_idle_st;
      endcase
    end
  end

  assign busy         = r_busy;
  assign result_valid = r_valid;
  assign quotient     = r_quot;
  assign remainder    = r_remd;
  assign sticky       = r_sticky;
`ifdef FPU_DIV_DBZ_EN
  assign dbz          = r_dbz;
`else
  assign dbz          = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_iter_div.sv
// tb/tb_fpu_iter_div.sv - scoreboard bench for fpu_iter_div with directed vectors
module tb_fpu_iter_div;

  localparam int W  = 24;
  localparam int QW = 27;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic          start = 1'b0;
  logic          mode_int = 1'b0;
  logic          ack = 1'b0;
  logic [W-1:0]  dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic          busy;
  logic          result_valid;
  logic [QW-1:0] quotient;
  logic [W:0]    remainder;
  logic          sticky;
  logic          dbz;

  fpu_iter_div #(.WIDTH(W), .QWIDTH(QW)) dut (
    .clk          (clk),
    .arst         (arst),
    .start        (start),
    .mode_int     (mode_int),
    .dividend     (dividend),
    .divisor      (divisor),
    .ack          (ack),
    .busy         (busy),
    .result_valid (result_valid),
    .quotient     (quotient),
    .remainder    (remainder),
    .sticky       (sticky),
    .dbz          (dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [QW-1:0] q;
    logic [W:0]    r;
    logic          s;
    logic          z;
    bit            chk_r;
    int            e0;
    int            lat;
    string         name;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  exp_t m_drop;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic prev_rv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, req);
    end
  endtask

  // Monitor: compare each new result against the oldest expectation.
  always @(negedge clk) begin
    if (result_valid && !prev_rv) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got quotient 0x%0h, want no result", quotient);
      end else begin
        m_e = sb.pop_front();
        check({m_e.name, "_quotient"}, quotient, m_e.q);
        if (m_e.chk_r) begin
          check({m_e.name, "_remainder"}, remainder, m_e.r);
          check({m_e.name, "_sticky"}, sticky, m_e.s);
        end
        check({m_e.name, "_dbz"}, dbz, m_e.z);
        check({m_e.name, "_latency"}, cyc - m_e.e0 + 1, m_e.lat);
      end
    end
    prev_rv <= result_valid;
  end

  task automatic issue(input string nm, input bit mi, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [QW-1:0] q, input logic [W:0] r, input bit s, input bit z,
                       input bit chk_r, input int lat);
    exp_t e;
    mode_int = mi;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.q = q; e.r = r; e.s = s; e.z = z; e.chk_r = chk_r;
    e.e0 = cyc + 1; e.lat = lat; e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_rv(input string nm, input int budget);
    int k;
    k = 0;
    while (!result_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!result_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: result_valid 0 after %0d cycles, want 1", nm, budget);
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_result_valid", result_valid, 1'b0);
    check("rst_quotient", quotient, '0);
    check("rst_remainder", remainder, '0);
    check("rst_sticky", sticky, 1'b0);
    check("rst_dbz", dbz, 1'b0);
    arst = 1'b0;
    @(negedge clk);

    issue("mant_1p5", 1'b0, 24'hC00000, 24'h800000, 27'h6000000, 25'h0, 1'b0, 1'b0, 1'b1, 28);
    wait_rv("mant_1p5", 40);
    do_ack();
    check("ack_busy_low", busy, 1'b0);
    check("ack_rv_low", result_valid, 1'b0);
    check("ack_quotient_kept", quotient, 27'h6000000);

    issue("mant_2_3", 1'b0, 24'h800000, 24'hC00000, 27'h2AAAAAA, 25'h800000, 1'b1, 1'b0, 1'b1, 28);
    wait_rv("mant_2_3", 40);
    do_ack();

    issue("int_100_7", 1'b1, 24'd100, 24'd7, 27'd14, 25'd2, 1'b1, 1'b0, 1'b1, 25);
    for (int i = 0; i < 5; i++) begin
      mode_int = 1'b0; dividend = 24'd50; divisor = 24'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_during_iter", busy, 1'b1);
      @(negedge clk);
    end
    wait_rv("int_100_7", 40);
    do_ack();

    issue("int_max_1", 1'b1, 24'hFFFFFF, 24'd1, 27'hFFFFFF, 25'd0, 1'b0, 1'b0, 1'b1, 25);
    wait_rv("int_max_1", 40);
    do_ack();

    issue("int_5_9", 1'b1, 24'd5, 24'd9, 27'd0, 25'd5, 1'b1, 1'b0, 1'b1, 25);
    wait_rv("int_5_9", 40);
    do_ack();

`ifdef FPU_DIV_DBZ_EN
    issue("dbz", 1'b0, 24'h900000, 24'h0, 27'h7FFFFFF, 25'h900000, 1'b1, 1'b1, 1'b1, 1);
`else
    issue("dbz", 1'b0, 24'h900000, 24'h0, 27'h7FFFFFF, 25'h0, 1'b0, 1'b0, 1'b0, 28);
`endif
    wait_rv("dbz", 40);
    do_ack();

    issue("mant_max", 1'b0, 24'hFFFFFF, 24'h800000, 27'h7FFFFF8, 25'h0, 1'b0, 1'b0, 1'b1, 28);
    wait_rv("mant_max", 40);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_rv", result_valid, 1'b1);
      check("hold_quotient", quotient, 27'h7FFFFF8);
    end
    ack = 1'b1;
    mode_int = 1'b1; dividend = 24'd9; divisor = 24'd3; start = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    start = 1'b0;
    check("ack_start_busy", busy, 1'b0);
    check("ack_start_rv", result_valid, 1'b0);
    issue("int_9_3", 1'b1, 24'd9, 24'd3, 27'd3, 25'd0, 1'b0, 1'b0, 1'b1, 25);
    check("next_start_busy", busy, 1'b1);
    wait_rv("int_9_3", 40);
    do_ack();

    issue("mant_rst", 1'b0, 24'hA00000, 24'h800000, 27'h5000000, 25'h0, 1'b0, 1'b0, 1'b1, 28);
    repeat (9) @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    @(posedge clk);
    #2 arst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_rv", result_valid, 1'b0);
    check("arst_quotient", quotient, '0);
    check("arst_remainder", remainder, '0);
    check("arst_sticky", sticky, 1'b0);
    check("arst_dbz", dbz, 1'b0);
    m_drop = sb.pop_back();
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    issue("mant_after_rst", 1'b0, 24'hA00000, 24'h800000, 27'h5000000, 25'h0, 1'b0, 1'b0, 1'b1, 28);
    wait_rv("mant_after_rst", 40);
    do_ack();

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
